// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and word/index types for the integer register file.
// Sub-modules derive their own widths from parameters; these are the core-wide defaults.
package regfile_pkg;
    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    typedef logic [AW_DEF-1:0]   reg_addr_t;
    typedef logic [XLEN_DEF-1:0] xword_t;
endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/write-back facing bus of the register file: write port, read ports, reservation.
// Reservation handshake: a reserve is taken at a rising clock when rsv_valid && rsv_ready;
// rsv_ready never looks at rsv_valid, and a refused requester holds rsv_valid/rsv_addr and retries.
interface reg_file_sb_if
    import regfile_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = NRD_DEF
);
    localparam int AW = $clog2(NREGS);
    localparam int CW = $clog2(NREGS + 1);

    logic                          wr_en;
    logic [AW-1:0]                 wr_addr;
    logic [XLEN-1:0]               wr_data;
    logic [NRD-1:0][AW-1:0]        rd_addr;
    logic [NRD-1:0][XLEN-1:0]      rd_data;
    logic [NRD-1:0]                rd_busy;
    logic                          rsv_valid;
    logic [AW-1:0]                 rsv_addr;
    logic                          rsv_ready;
    logic [CW-1:0]                 busy_count;

    modport master (
        output wr_en, wr_addr, wr_data, rd_addr, rsv_valid, rsv_addr,
        input  rd_data, rd_busy, rsv_ready, busy_count
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_addr, rsv_valid, rsv_addr,
        output rd_data, rd_busy, rsv_ready, busy_count
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Per-register busy scoreboard: reservations set a bit, write-backs clear it,
// and a same-cycle reserve of the register being written leaves it busy.
module reg_scoreboard #(
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NREGS),
    localparam int CW      = $clog2(NREGS + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ready,
    output logic [NREGS-1:0] busy,
    output logic [CW-1:0]    busy_count
);
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    count_d;
    logic             rsv_take;

    // A write landing this cycle frees the register, so it may be re-reserved at once.
    assign rsv_ready = !busy[rsv_addr] || (wr_en && (wr_addr == rsv_addr));
    assign rsv_take  = rsv_valid && rsv_ready && !(ZERO_REG && (rsv_addr == '0));

    always_comb begin
        busy_d = busy;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (rsv_take) begin
            busy_d[rsv_addr] = 1'b1;
        end
        count_d = '0;
        for (int i = 0; i < NREGS; i++) begin
            count_d = count_d + CW'(busy_d[i]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy       <= '0;
            busy_count <= '0;
        end else begin
            busy       <= busy_d;
            busy_count <= count_d;
        end
    end
endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: NRD combinational read ports, one write port, optional
// write-to-read bypass and hard-wired zero register, plus the busy scoreboard.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = NRD_DEF,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic           clock,
    input  logic           reset,
    reg_file_sb_if.slave   bus
);
    logic [XLEN-1:0]           regs [NREGS];
    logic [NREGS-1:0]          busy;
    logic [NRD-1:0][XLEN-1:0]  rd_data_c;
    logic [NRD-1:0]            rd_busy_c;
    logic                      wr_store;
    logic                      wr_fwd;

    assign wr_store = bus.wr_en && !(ZERO_REG && (bus.wr_addr == '0));
    // Nothing is forwarded while reset holds the file cleared.
    assign wr_fwd   = BYPASS && bus.wr_en && reset;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_store) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_data_c[i] = regs[bus.rd_addr[i]];
            rd_busy_c[i] = busy[bus.rd_addr[i]];
            if (wr_fwd && (bus.wr_addr == bus.rd_addr[i])) begin
                rd_data_c[i] = bus.wr_data;
                rd_busy_c[i] = 1'b0;
            end
            if (ZERO_REG && (bus.rd_addr[i] == '0)) begin
                rd_data_c[i] = '0;
                rd_busy_c[i] = 1'b0;
            end
        end
    end

    assign bus.rd_data = rd_data_c;
    assign bus.rd_busy = rd_busy_c;

    reg_scoreboard #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .wr_en      (bus.wr_en),
        .wr_addr    (bus.wr_addr),
        .rsv_valid  (bus.rsv_valid),
        .rsv_addr   (bus.rsv_addr),
        .rsv_ready  (bus.rsv_ready),
        .busy       (busy),
        .busy_count (bus.busy_count)
    );
endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb with four read ports, bypass and zero register on.
// A plain array model of registers and busy bits supplies every expected value.
module tb_reg_file_sb;
    import regfile_pkg::*;

    localparam int  XLEN  = 64;
    localparam int  NREGS = 32;
    localparam int  NRD   = 4;
    localparam bit  BYPASS = 1'b1;
    localparam int  CW    = $clog2(NREGS + 1);

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_busy [NREGS];
    logic [CW-1:0]   exp_q [$];

    reg_file_sb_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

    reg_file_sb #(
        .XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .ZERO_REG(1'b1), .BYPASS(BYPASS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // ---------------- reference model ----------------
    function automatic void model_clear();
        for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic logic [CW-1:0] m_pop();
        int n = 0;
        for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
        return CW'(n);
    endfunction

    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (BYPASS && bus.wr_en && int'(bus.wr_addr) == a) return bus.wr_data;
        return m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (BYPASS && bus.wr_en && int'(bus.wr_addr) == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ready();
        int ra = int'(bus.rsv_addr);
        return !m_busy[ra] || (bus.wr_en && int'(bus.wr_addr) == ra);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.rsv_valid = 1'b0;
        bus.rsv_addr  = '0;
        for (int i = 0; i < NRD; i++) bus.rd_addr[i] = '0;
    endtask

    task automatic set_reads(input int a);
        for (int i = 0; i < NRD; i++) bus.rd_addr[i] = 5'(a);
    endtask

    // One rising edge; the model takes the same inputs the DUT sampled.
    task automatic tick();
        bit ready_m;
        int wa;
        int ra;
        @(posedge clock);
        if (reset) begin
            wa = int'(bus.wr_addr);
            ra = int'(bus.rsv_addr);
            ready_m = exp_ready();
            if (bus.wr_en) begin
                if (wa != 0) m_regs[wa] = bus.wr_data;
                m_busy[wa] = 1'b0;
            end
            if (bus.rsv_valid && ready_m && ra != 0) m_busy[ra] = 1'b1;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (bus.rd_data[0] !== '0 || bus.rd_busy !== '0 || bus.busy_count !== '0 || bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_init: rd_data0=%h rd_busy=%b count=%0d ready=%b required 0/0/0/1",
                     bus.rd_data[0], bus.rd_busy, bus.busy_count, bus.rsv_ready);
        end
        reset = 1'b1;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hAB;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd6;
        tick();
        set_idle();
        set_reads(5);
        #1;
        checks++;
        if (bus.rd_data[0] !== 64'hAB || bus.busy_count !== 1) begin
            errors++;
            $display("FAIL reset_prewrite: rd_data=%h count=%0d required ab/1", bus.rd_data[0], bus.busy_count);
        end
        reset = 1'b0;
        model_clear();
        #1;
        checks++;
        if (bus.rd_data[0] !== '0 || bus.busy_count !== '0 || bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_pulse: rd_data=%h count=%0d ready=%b required 0/0/1",
                     bus.rd_data[0], bus.busy_count, bus.rsv_ready);
        end
        bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'h77;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd5;
        tick();
        set_idle();
        set_reads(5);
        #1;
        checks++;
        if (bus.rd_data[0] !== '0 || bus.rd_busy[0] !== 1'b0 || bus.busy_count !== '0) begin
            errors++;
            $display("FAIL reset_hold: rd_data=%h busy=%b count=%0d required 0/0/0",
                     bus.rd_data[0], bus.rd_busy[0], bus.busy_count);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_write_bypass();
        set_idle();
        set_reads(3);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h1234;
        #1;
        checks++;
        if (bus.rd_data[0] !== exp_data(3) || bus.rd_data[0] !== 64'h1234) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h required %h", bus.rd_data[0], exp_data(3));
        end
        tick();
        set_idle();
        set_reads(3);
        #1;
        checks++;
        if (bus.rd_data[1] !== 64'h1234) begin
            errors++;
            $display("FAIL write_next_cycle: got %h required 1234", bus.rd_data[1]);
        end
    endtask

    task automatic test_reserve();
        set_idle();
        set_reads(7);
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd7;
        #1;
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL rsv_first_ready: got %b required 1", bus.rsv_ready);
        end
        tick();
        #1;
        checks++;
        if (bus.rd_busy[0] !== 1'b1 || bus.busy_count !== 1 || bus.rsv_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsv_busy: rd_busy=%b count=%0d ready=%b required 1/1/0",
                     bus.rd_busy[0], bus.busy_count, bus.rsv_ready);
        end
        tick();
        bus.rsv_valid = 1'b0;
        bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'h55;
        checks++;
        if (bus.busy_count !== 1) begin
            errors++;
            $display("FAIL rsv_refused: count=%0d required 1", bus.busy_count);
        end
        tick();
        set_idle();
        set_reads(7);
        #1;
        checks++;
        if (bus.rd_busy[2] !== 1'b0 || bus.busy_count !== 0 || bus.rd_data[2] !== 64'h55) begin
            errors++;
            $display("FAIL rsv_release: rd_busy=%b count=%0d data=%h required 0/0/55",
                     bus.rd_busy[2], bus.busy_count, bus.rd_data[2]);
        end
    endtask

    task automatic test_same_cycle();
        set_idle();
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd9;
        tick();
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h99;
        #1;
        checks++;
        if (bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL same_cycle_ready: got %b required 1", bus.rsv_ready);
        end
        tick();
        set_idle();
        set_reads(9);
        #1;
        checks++;
        if (bus.rd_data[3] !== 64'h99 || bus.rd_busy[3] !== 1'b1 || bus.busy_count !== 1) begin
            errors++;
            $display("FAIL same_cycle_win: data=%h busy=%b count=%0d required 99/1/1",
                     bus.rd_data[3], bus.rd_busy[3], bus.busy_count);
        end
        bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'h99;
        tick();
        set_idle();
    endtask

    task automatic test_zero_reg();
        set_idle();
        set_reads(0);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_data = 64'hFFFF;
        bus.rsv_valid = 1'b1; bus.rsv_addr = 5'd0;
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.rsv_ready !== 1'b1) begin
            errors++;
            $display("FAIL zero_same_cycle: rd_data=%h busy=%b ready=%b required 0/0/1",
                     bus.rd_data, bus.rd_busy, bus.rsv_ready);
        end
        tick();
        set_idle();
        set_reads(0);
        #1;
        checks++;
        if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.busy_count !== '0) begin
            errors++;
            $display("FAIL zero_after: rd_data=%h busy=%b count=%0d required 0/0/0",
                     bus.rd_data, bus.rd_busy, bus.busy_count);
        end
    endtask

    task automatic test_multiport();
        set_idle();
        set_reads(12);
        bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 64'hC0FFEE;
        #1;
        for (int i = 0; i < NRD; i++) begin
            checks++;
            if (bus.rd_data[i] !== 64'hC0FFEE || bus.rd_busy[i] !== 1'b0) begin
                errors++;
                $display("FAIL multiport_p%0d: data=%h busy=%b required c0ffee/0", i, bus.rd_data[i], bus.rd_busy[i]);
            end
        end
        tick();
        set_idle();
        set_reads(12);
        #1;
        checks++;
        if (bus.rd_data[0] !== 64'hC0FFEE || bus.rd_data[3] !== 64'hC0FFEE) begin
            errors++;
            $display("FAIL multiport_stored: p0=%h p3=%h required c0ffee", bus.rd_data[0], bus.rd_data[3]);
        end
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_cnt;
        for (int n = 0; n < 400; n++) begin
            bus.wr_en     = ($urandom_range(0, 2) == 0);
            bus.wr_addr   = 5'($urandom_range(0, 7));
            bus.wr_data   = {$urandom(), $urandom()};
            bus.rsv_valid = ($urandom_range(0, 1) == 1);
            bus.rsv_addr  = 5'($urandom_range(0, 7));
            for (int i = 0; i < NRD; i++) bus.rd_addr[i] = 5'($urandom_range(0, 9));
            #1;
            for (int i = 0; i < NRD; i++) begin
                checks++;
                if (bus.rd_data[i] !== exp_data(int'(bus.rd_addr[i])) ||
                    bus.rd_busy[i] !== exp_busy(int'(bus.rd_addr[i]))) begin
                    errors++;
                    $display("FAIL rand_read n=%0d p%0d a=%0d: data=%h busy=%b required %h/%b", n, i,
                             bus.rd_addr[i], bus.rd_data[i], bus.rd_busy[i],
                             exp_data(int'(bus.rd_addr[i])), exp_busy(int'(bus.rd_addr[i])));
                end
            end
            checks++;
            if (bus.rsv_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready n=%0d: got %b required %b", n, bus.rsv_ready, exp_ready());
            end
            tick();
            exp_q.push_back(m_pop());
            exp_cnt = exp_q.pop_front();
            checks++;
            if (bus.busy_count !== exp_cnt) begin
                errors++;
                $display("FAIL rand_count n=%0d: got %0d required %0d", n, bus.busy_count, exp_cnt);
            end
        end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        model_clear();
        set_idle();
        test_reset();
        test_write_bypass();
        test_reserve();
        test_same_cycle();
        test_zero_reg();
        test_multiport();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
